decode_ctrl_stage: RTL and testbench

//  Parametrised successor to the combinational decode control: decodes RV32I (+ optional M)

---
 rtl/decode_ctrl_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// ============================================================================
// decode_ctrl_stage : RV32I (+M) decode registered into the ID/EX control reg
// Rev 1.0
// ============================================================================
`default_nettype none

module decode_ctrl_stage #(
  parameter int EN_MEXT = 1,
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               ex_memread_i,
  input  logic [4:0]         ex_rd_i,
  output logic               valid_o,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               PCBranchE,
  output logic               SrcBSelE,
  output logic               MemtoRegE,
  output logic [1:0]         SrcASelE,
  output logic [ALUOP_W-1:0] ALUopE,
  output logic [2:0]         immSelE,
  output logic [2:0]         strCtrlE,
  output logic [4:0]         rs1E,
  output logic [4:0]         rs2E,
  output logic [4:0]         rdE,
  output logic               illegal_o,
  output logic               trap_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic               regWrite;
    logic               memWrite;
    logic               pcBranch;
    logic               srcBSel;
    logic               memtoReg;
    logic [1:0]         srcASel;
    logic [ALUOP_W-1:0] aluOp;
    logic [2:0]         immSel;
    logic [2:0]         strCtrl;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
  } ctrl_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  logic [6:0] wOpcode;
  logic [2:0] wFunct3;
  logic [6:0] wFunct7;
  ctrl_t      wDec;
  logic [4:0] wAluOp;
  logic       wLegal;
  logic       wRs1Used;
  logic       wRs2Used;
  logic       wHazard;

  state_t     rState;
  ctrl_t      rCtrl;
  logic       rValid;
  logic       rIllegal;
  logic [CNT_W-1:0] rBubbleCnt;

  assign wOpcode = instr_i[6:0];
  assign wFunct3 = instr_i[14:12];
  assign wFunct7 = instr_i[31:25];

  always_comb begin
    wDec     = '0;
    wAluOp   = 5'd0;
    wLegal   = 1'b1;
    wRs1Used = 1'b1;
    wRs2Used = 1'b0;
    wDec.srcASel = 2'b10;
    case (wOpcode)
      OP_LOAD: begin
        wDec.regWrite = 1'b1;
        wDec.memtoReg = 1'b1;
        wDec.srcBSel  = 1'b1;
      end
      OP_STORE: begin
        wDec.memWrite = 1'b1;
        wDec.srcBSel  = 1'b1;
        wDec.immSel   = 3'd1;
        wRs2Used      = 1'b1;
      end
      OP_BRANCH: begin
        wDec.pcBranch = 1'b1;
        wDec.immSel   = 3'd2;
        wAluOp        = {2'b00, wFunct3};
        wRs2Used      = 1'b1;
      end
      OP_JALR: begin
        wDec.regWrite = 1'b1;
        wDec.pcBranch = 1'b1;
        wDec.srcASel  = 2'b00;
      end
      OP_JAL: begin
        wDec.regWrite = 1'b1;
        wDec.pcBranch = 1'b1;
        wDec.srcASel  = 2'b00;
        wDec.immSel   = 3'd4;
        wRs1Used      = 1'b0;
      end
      OP_IMM: begin
        wDec.regWrite = 1'b1;
        wDec.srcBSel  = 1'b1;
        // Only the shift-right group distinguishes SRLI/SRAI via funct7[5]
        wAluOp = (wFunct3 == 3'b101) ? {1'b0, wFunct7[5], wFunct3} : {2'b00, wFunct3};
      end
      OP_REG: begin
        wDec.regWrite = 1'b1;
        wRs2Used      = 1'b1;
        if (wFunct7 == F7_MEXT) begin
          wAluOp = {2'b10, wFunct3};
          wLegal = (EN_MEXT != 0);
        end else if (wFunct7 == F7_BASE || wFunct7 == F7_ALT) begin
          wAluOp = {1'b0, wFunct7[5], wFunct3};
        end else begin
          wLegal = 1'b0;
        end
      end
      OP_LUI: begin
        wDec.regWrite = 1'b1;
        wDec.srcBSel  = 1'b1;
        wDec.srcASel  = 2'b01;
        wDec.immSel   = 3'd3;
        wRs1Used      = 1'b0;
      end
      OP_AUIPC: begin
        wDec.regWrite = 1'b1;
        wDec.srcBSel  = 1'b1;
        wDec.srcASel  = 2'b00;
        wDec.immSel   = 3'd3;
        wRs1Used      = 1'b0;
      end
      default: wLegal = 1'b0;
    endcase
    wDec.aluOp   = wAluOp[ALUOP_W-1:0];
    wDec.strCtrl = wFunct3;
    wDec.rs1     = instr_i[19:15];
    wDec.rs2     = instr_i[24:20];
    wDec.rd      = instr_i[11:7];
  end

  // Load-use: the EX load result is not yet forwardable, so ID must wait one cycle
  assign wHazard = valid_i & ex_memread_i & (ex_rd_i != 5'd0) &
                   ((wRs1Used & (instr_i[19:15] == ex_rd_i)) |
                    (wRs2Used & (instr_i[24:20] == ex_rd_i)));

  assign ready_o = rst_n & (rState == RUN) & ~stall_i & ~wHazard & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rState     <= RUN;
      rCtrl      <= '0;
      rValid     <= 1'b0;
      rIllegal   <= 1'b0;
      rBubbleCnt <= '0;
    end else if (flush_i) begin
      rState   <= RUN;
      rCtrl    <= '0;
      rValid   <= 1'b0;
      rIllegal <= 1'b0;
    end else if (!stall_i) begin
      if (rState == TRAP) begin
        rCtrl    <= '0;
        rValid   <= 1'b0;
        rIllegal <= 1'b0;
      end else if (wHazard) begin
        rCtrl    <= '0;
        rValid   <= 1'b0;
        rIllegal <= 1'b0;
        if (rBubbleCnt != CNT_MAX)
          rBubbleCnt <= rBubbleCnt + CNT_ONE;
      end else if (valid_i && wLegal) begin
        rCtrl    <= wDec;
        rValid   <= 1'b1;
        rIllegal <= 1'b0;
      end else if (valid_i) begin
        rCtrl    <= '0;
        rValid   <= 1'b0;
        rIllegal <= 1'b1;
        rState   <= TRAP;
      end else begin
        rCtrl    <= '0;
        rValid   <= 1'b0;
        rIllegal <= 1'b0;
      end
    end
  end

  assign valid_o      = rValid;
  assign illegal_o    = rIllegal;
  assign trap_o       = (rState == TRAP);
  assign bubble_cnt_o = rBubbleCnt;
  assign RegWriteE    = rCtrl.regWrite;
  assign MemWriteE    = rCtrl.memWrite;
  assign PCBranchE    = rCtrl.pcBranch;
  assign SrcBSelE     = rCtrl.srcBSel;
  assign MemtoRegE    = rCtrl.memtoReg;
  assign SrcASelE     = rCtrl.srcASel;
  assign ALUopE       = rCtrl.aluOp;
  assign immSelE      = rCtrl.immSel;
  assign strCtrlE     = rCtrl.strCtrl;
  assign rs1E         = rCtrl.rs1;
  assign rs2E         = rCtrl.rs2;
  assign rdE          = rCtrl.rd;

endmodule

`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
// ============================================================================
// tb_decode_ctrl_stage : directed + random check of decode_ctrl_stage (M on/off)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_decode_ctrl_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        validI, stall, flush, exMr;
  logic [4:0]  exRd;

  logic       readyO[2], validO[2], regWriteE[2], memWriteE[2], pcBranchE[2];
  logic       srcBSelE[2], memtoRegE[2], illegalO[2], trapO[2];
  logic [1:0] srcASelE[2];
  logic [2:0] immSelE[2], strCtrlE[2];
  logic [4:0] rs1E[2], rs2E[2], rdE[2];
  logic [4:0] aluA;
  logic [3:0] aluB;
  logic [1:0] cntA;
  logic [15:0] cntB;

  int nChecks = 0;
  int nFail   = 0;

  decode_ctrl_stage #(.EN_MEXT(1), .ALUOP_W(5), .CNT_W(2)) dutM (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .valid_i(validI), .ready_o(readyO[0]),
    .stall_i(stall), .flush_i(flush), .ex_memread_i(exMr), .ex_rd_i(exRd),
    .valid_o(validO[0]), .RegWriteE(regWriteE[0]), .MemWriteE(memWriteE[0]),
    .PCBranchE(pcBranchE[0]), .SrcBSelE(srcBSelE[0]), .MemtoRegE(memtoRegE[0]),
    .SrcASelE(srcASelE[0]), .ALUopE(aluA), .immSelE(immSelE[0]), .strCtrlE(strCtrlE[0]),
    .rs1E(rs1E[0]), .rs2E(rs2E[0]), .rdE(rdE[0]), .illegal_o(illegalO[0]),
    .trap_o(trapO[0]), .bubble_cnt_o(cntA)
  );

  decode_ctrl_stage #(.EN_MEXT(0), .ALUOP_W(4), .CNT_W(16)) dutI (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .valid_i(validI), .ready_o(readyO[1]),
    .stall_i(stall), .flush_i(flush), .ex_memread_i(exMr), .ex_rd_i(exRd),
    .valid_o(validO[1]), .RegWriteE(regWriteE[1]), .MemWriteE(memWriteE[1]),
    .PCBranchE(pcBranchE[1]), .SrcBSelE(srcBSelE[1]), .MemtoRegE(memtoRegE[1]),
    .SrcASelE(srcASelE[1]), .ALUopE(aluB), .immSelE(immSelE[1]), .strCtrlE(strCtrlE[1]),
    .rs1E(rs1E[1]), .rs2E(rs2E[1]), .rdE(rdE[1]), .illegal_o(illegalO[1]),
    .trap_o(trapO[1]), .bubble_cnt_o(cntB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode tables indexed by instruction class:
  // 0 load, 1 store, 2 branch, 3 jalr, 4 jal, 5 alu-imm, 6 alu-reg, 7 lui, 8 auipc
  localparam logic [6:0] OPC [9] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h13, 7'h33, 7'h37, 7'h17};
  localparam logic [8:0] RW_K   = 9'b111111001;
  localparam logic [8:0] MW_K   = 9'b000000010;
  localparam logic [8:0] MTR_K  = 9'b000000001;
  localparam logic [8:0] PCB_K  = 9'b000011100;
  localparam logic [8:0] SRCB_K = 9'b110100011;
  localparam logic [8:0] U1_K   = 9'b001101111;
  localparam logic [8:0] U2_K   = 9'b001000110;
  localparam int SRCA_K [9] = '{2, 2, 2, 0, 0, 2, 2, 1, 0};
  localparam int IMM_K  [9] = '{0, 1, 2, 0, 4, 0, 0, 3, 3};

  typedef struct packed {
    bit       legal, rw, mw, mtr, pcb, srcb, u1, u2;
    bit [1:0] srca;
    bit [4:0] alu;
    bit [2:0] imm, f3;
    bit [4:0] rs1, rs2, rd;
  } dec_t;

  function automatic dec_t refDecode(input logic [31:0] ins, input bit enM);
    dec_t d;
    int   k;
    int   f3, f7;
    d  = '0;
    k  = -1;
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    for (int i = 0; i < 9; i++) if (ins[6:0] == OPC[i]) k = i;
    d.f3  = ins[14:12];
    d.rs1 = ins[19:15];
    d.rs2 = ins[24:20];
    d.rd  = ins[11:7];
    if (k < 0) begin
      d.u1 = 1'b1;
      return d;
    end
    d.legal = 1'b1;
    d.rw = RW_K[k]; d.mw = MW_K[k]; d.mtr = MTR_K[k]; d.pcb = PCB_K[k];
    d.srcb = SRCB_K[k]; d.u1 = U1_K[k]; d.u2 = U2_K[k];
    d.srca = 2'(SRCA_K[k]);
    d.imm  = 3'(IMM_K[k]);
    if (k == 2) d.alu = 5'(f3);
    if (k == 5) d.alu = 5'((f3 == 5) ? (f7 / 32 % 2) * 8 + f3 : f3);
    if (k == 6) begin
      if (f7 == 1) begin
        d.legal = enM;
        d.alu   = 5'(16 + f3);
      end else if (f7 == 0 || f7 == 32) begin
        d.alu = 5'((f7 / 32) * 8 + f3);
      end else begin
        d.legal = 1'b0;
      end
    end
    return d;
  endfunction

  // Expected registered state per DUT (0: M enabled, 2-bit counter; 1: base only, 16-bit)
  bit   mValid[2], mIll[2], mTrap[2];
  int   mCnt[2];
  dec_t mCtl[2];
  localparam int CNT_LIMIT [2] = '{3, 65535};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit refHazard();
    dec_t d;
    d = refDecode(instr, 1'b1);
    return validI && exMr && exRd != 0 &&
           ((d.u1 && d.rs1 == exRd) || (d.u2 && d.rs2 == exRd));
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mValid[k] = 0; mIll[k] = 0; mTrap[k] = 0; mCnt[k] = 0; mCtl[k] = '0;
    end
  endtask

  task automatic modelEdge(input int k);
    dec_t d;
    d = refDecode(instr, (k == 0));
    if (flush) begin
      mValid[k] = 0; mIll[k] = 0; mCtl[k] = '0; mTrap[k] = 0;
    end else if (stall) begin
    end else if (mTrap[k]) begin
      mValid[k] = 0; mIll[k] = 0; mCtl[k] = '0;
    end else if (refHazard()) begin
      mValid[k] = 0; mIll[k] = 0; mCtl[k] = '0;
      if (mCnt[k] < CNT_LIMIT[k]) mCnt[k]++;
    end else if (validI && d.legal) begin
      mValid[k] = 1; mIll[k] = 0; mCtl[k] = d;
    end else if (validI) begin
      mValid[k] = 0; mIll[k] = 1; mCtl[k] = '0; mTrap[k] = 1;
    end else begin
      mValid[k] = 0; mIll[k] = 0; mCtl[k] = '0;
    end
  endtask

  task automatic checkRegs(input int k);
    string p;
    p = $sformatf("dut%0d", k);
    chk({p, ".valid"},   validO[k],   mValid[k]);
    chk({p, ".illegal"}, illegalO[k], mIll[k]);
    chk({p, ".trap"},    trapO[k],    mTrap[k]);
    chk({p, ".cnt"},     (k == 0) ? 32'(cntA) : 32'(cntB), mCnt[k]);
    chk({p, ".regWrite"}, regWriteE[k], mCtl[k].rw);
    chk({p, ".memWrite"}, memWriteE[k], mCtl[k].mw);
    chk({p, ".pcBranch"}, pcBranchE[k], mCtl[k].pcb);
    if (mValid[k]) begin
      chk({p, ".srcB"},     srcBSelE[k],  mCtl[k].srcb);
      chk({p, ".memtoReg"}, memtoRegE[k], mCtl[k].mtr);
      chk({p, ".srcA"},     srcASelE[k],  mCtl[k].srca);
      chk({p, ".aluop"}, (k == 0) ? 32'(aluA) : 32'(aluB),
          (k == 0) ? 32'(mCtl[k].alu) : 32'(mCtl[k].alu[3:0]));
      chk({p, ".immSel"},  immSelE[k],  mCtl[k].imm);
      chk({p, ".strCtrl"}, strCtrlE[k], mCtl[k].f3);
      chk({p, ".rs1"},     rs1E[k],     mCtl[k].rs1);
      chk({p, ".rs2"},     rs2E[k],     mCtl[k].rs2);
      chk({p, ".rd"},      rdE[k],      mCtl[k].rd);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.dut%0d.ready", tag, k), readyO[k], 0);
      chk($sformatf("%s.dut%0d.outs", tag, k),
          {validO[k], regWriteE[k], memWriteE[k], pcBranchE[k], srcBSelE[k], memtoRegE[k],
           srcASelE[k], immSelE[k], strCtrlE[k], illegalO[k], trapO[k]}, 0);
      chk($sformatf("%s.dut%0d.regs", tag, k), {rs1E[k], rs2E[k], rdE[k]}, 0);
    end
    chk({tag, ".alu"}, {aluA, aluB}, 0);
    chk({tag, ".cnt"}, {cntA, cntB}, 0);
  endtask

  task automatic drive(input logic [31:0] ins, input bit v, st, fl, mr, input logic [4:0] rd);
    @(negedge clk);
    instr = ins; validI = v; stall = st; flush = fl; exMr = mr; exRd = rd;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("dut%0d.ready", k), readyO[k],
          !mTrap[k] && !stall && !flush && !refHazard());
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) modelEdge(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) checkRegs(k);
  endtask

  task automatic step(input logic [31:0] ins, input bit v, st, fl, mr, input logic [4:0] rd);
    drive(ins, v, st, fl, mr, rd);
    tick();
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel == 11) return 32'h0;
    if (sel < 9) r[6:0] = OPC[sel];
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    if (r[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] MUL  = 32'h022083B3;
  localparam logic [31:0] USE5 = 32'h00128333;

  initial begin
    rst_n = 1'b0; instr = '0; validI = 0; stall = 0; flush = 0; exMr = 0; exRd = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(ADD, 1, 0, 0, 0, 0);
    chk("add.valid", validO[0], 1);
    chk("add.regWrite", regWriteE[0], 1);
    chk("add.aluop", aluA, 5'b00000);
    chk("add.rd", rdE[0], 3);

    step(SUB, 1, 0, 0, 0, 0);
    chk("sub.aluop5", aluA, 5'b01000);
    chk("sub.aluop4", aluB, 4'b1000);

    step(MUL, 1, 0, 0, 0, 0);
    chk("mul.aluop", aluA, 5'b10000);
    chk("mul.noM.illegal", illegalO[1], 1);
    chk("mul.noM.trap", trapO[1], 1);
    step(32'h0, 0, 0, 1, 0, 0);

    drive(USE5, 1, 0, 0, 1, 5);
    chk("loaduse.ready", readyO[0], 0);
    tick();
    chk("loaduse.bubble", cntA, 1);
    step(USE5, 1, 0, 0, 0, 0);
    chk("loaduse.issue", {validO[0], rdE[0]}, {1'b1, 5'd6});
    step(USE5, 1, 0, 0, 1, 0);
    chk("x0.nobubble", {validO[0], cntA}, {1'b1, 2'd1});

    step(32'h0, 1, 0, 0, 0, 0);
    chk("zero.illegal", {illegalO[0], trapO[0]}, 2'b11);
    drive(ADD, 1, 0, 0, 0, 0);
    chk("trap.ready", readyO[0], 0);
    tick();
    chk("trap.pulse", {illegalO[0], trapO[0], validO[0]}, 3'b010);
    step(ADD, 1, 0, 1, 0, 0);
    drive(ADD, 1, 0, 0, 0, 0);
    chk("flush.ready", readyO[0], 1);
    tick();

    step(ADD, 1, 1, 1, 0, 0);
    chk("stallflush.valid", validO[0], 0);

    step(ADD, 1, 0, 0, 0, 0);
    repeat (3) step(SUB, 1, 1, 0, 0, 0);
    chk("stall.held", {validO[0], aluA}, {1'b1, 5'b00000});
    step(SUB, 1, 0, 0, 0, 0);

    repeat (4) step(USE5, 1, 0, 0, 1, 5);
    chk("sat.cntA", cntA, 2'd3);
    chk("sat.cntB", cntB, 16'd5);

    drive(ADD, 1, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAllZero("midreset");
    @(posedge clk);
    #1;
    checkAllZero("midreset.hold");
    @(negedge clk);
    rst_n = 1'b1;
    stall = 0;

    for (int n = 0; n < 600; n++)
      step(randInstr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
